ans_display: RTL
================

// Module: ans_display
// PURPOSE
//  Consumer end of the calculator result bus. Takes the 32-bit ans word from the arithmetic
//  block and decodes it for a multiplexed 6-digit 7-segment display. Decoding covers signed
//  decimal values and the two special codes 0x00CC0000 (NULL) and 0x00EE0000 (error).
//  Binary-to-BCD uses a sequential double-dabble engine; the display is scanned one digit at a time.
// PARAMETERS
//  DIGITS    6      number of display digits (fixed at 6; the magnitude path is sized for it)
//  SCAN_DIV  50000  sw_clk cycles per digit slot in the scan
// PORTS
//  sw_clk     in   1       block clock; all logic on posedge
//  rst        in   1       asynchronous, active-low reset
//  ans        in   32      result word from the calculator; may change at any cycle
//  seg        out  8       segments {dp,g,f,e,d,c,b,a}, active-low
//  digit_sel  out  DIGITS  digit enable, one-hot active-low; bit0 = rightmost digit
//  busy       out  1       high while a conversion is in progress
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; busy=0; shadow=0x00CC0000.
//   - All digit registers are blank; seg=8'hFF; digit_sel={DIGITS{1'b1}}.
//   - Scan counter and digit index are cleared.
//   - Reset mid-conversion discards the conversion; no partial update reaches the display.
//  Capture:
//   - In IDLE, each cycle compare ans with shadow.
//   - On mismatch: latch ans into shadow and a work register, then go to LOAD.
//   - ans changes outside IDLE are ignored until the next return to IDLE, where the compare
//     re-runs. Only the latest value is ever displayed.
//  Classification in LOAD (1 cycle):
//   - ans==0x00CC0000 -> NULL -> go to FORMAT.
//   - ans==0x00EE0000, or signed ans >= 1_000_000, or signed ans <= -100_000 -> ERR -> go to FORMAT.
//   - Otherwise: neg=ans[31]; mag = neg ? -ans : ans, truncated to 20 bits.
//     Clear the 24-bit BCD register and go to SHIFT.
//  SHIFT (exactly 20 cycles):
//   - Each cycle, add 3 to every BCD nibble >= 5.
//   - Then shift {bcd,mag} left by 1.
//   - A 5-bit counter counts 0..19; at 19, go to FORMAT.
//  FORMAT (1 cycle): all 6 digit registers are written together, then go to IDLE.
//   - NULL: all digits blank.
//   - ERR: digits 5..1 = E,r,r,o,r; digit0 blank.
//   - Numeric: leading zeros blanked; value 0 shows "0" in digit0.
//     If neg, a minus goes in the digit directly left of the most-significant non-blank digit.
//     Magnitude is <= 99999 when neg, so the minus always fits.
//  Latency from ans change seen in IDLE (cycle 0) to new digits visible on the scan:
//   - Numeric: cycle 23. Timeline: LOAD c1, SHIFT c2..21, FORMAT c22.
//   - NULL/ERR: cycle 3.
//  busy = 1 in LOAD, SHIFT and FORMAT; 0 in IDLE.
//  Segment codes (g..a, active-low):
//   - Digits 0-9 use standard patterns; e.g. 0=1000000, 1=1111001, 8=0000000.
//   - Symbols: minus=0111111, blank=1111111, E=0000110, r=0101111, o=0100011.
//   - dp is always 1 (off).
//  Scan:
//   - Free-running counter 0..SCAN_DIV-1. On wrap, digit index advances 0->1->...->DIGITS-1->0.
//   - digit_sel = ~(1<<index); seg = code of digit[index].
//   - Both outputs are registered and change on the same edge.
//   - The first slot after reset release is index 0.
// TESTING
//  1. ans=123456 from IDLE -> busy 1 for cycles 1..22; digits "123456" from cycle 23.
//  2. ans=-42 -> digits 5..3 blank, digit2 minus, digit1 '4', digit0 '2'.
//     ans=0 -> only digit0 shows '0'.
//  3. ans=0x00EE0000 -> "Error" on digits 5..1, digit0 blank, at cycle 3.
//     Then ans=0x00CC0000 -> all blank at cycle 3.
//  4. ans=111111, then 222222 at cycle 10 -> 111111 shown at cycle 23.
//     Re-capture in IDLE at cycle 23; 222222 shown at cycle 46.
//  5. Assert rst during SHIFT -> seg=8'hFF, digit_sel all 1, busy=0 immediately.
//     After release with ans=0x00CC0000 -> no conversion starts.
//  6. SCAN_DIV=4 -> digit_sel steps 111110, 111101, ..., 011111 every 4 cycles, then wraps to 111110.
//     seg matches the digit at each step.

Source files
------------

// File: rtl/ans_display.sv
// Result-bus display: decodes the calculator ans word (signed decimal, NULL, error)
// with a sequential double-dabble and scans it onto a 6-digit active-low 7-segment display.
module ans_display #(
   parameter int DIGITS   = 6,
   parameter int SCAN_DIV = 50000
) (
   input  logic              sw_clk,
   input  logic              rst,
   input  logic [31:0]       ans,
   output logic [7:0]        seg,
   output logic [DIGITS-1:0] digit_sel,
   output logic              busy
);

   localparam logic [31:0] ANS_NULL = 32'h00CC_0000;
   localparam logic [31:0] ANS_ERR  = 32'h00EE_0000;
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Symbol codes stored in the digit registers; 0..9 are plain BCD
   localparam logic [3:0] SYM_MINUS = 4'd10;
   localparam logic [3:0] SYM_BLANK = 4'd11;
   localparam logic [3:0] SYM_E     = 4'd12;
   localparam logic [3:0] SYM_R     = 4'd13;
   localparam logic [3:0] SYM_O     = 4'd14;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FORMAT} state_t;
   typedef enum logic [1:0] {K_NUM, K_NULL, K_ERR} kind_t;

   state_t            state_q, state_d;
   kind_t             kind_q, kind_d;
   logic [31:0]       shadow_q, shadow_d;
   logic [31:0]       work_q, work_d;
   logic [19:0]       mag_q, mag_d;
   logic [23:0]       bcd_q, bcd_d;
   logic              neg_q, neg_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [3:0]        digit_q [DIGITS];
   logic [3:0]        digit_d [DIGITS];
   logic [3:0]        fmt [DIGITS];
   logic [CW-1:0]     scan_q, scan_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   logic [31:0]       abs_w;
   logic [23:0]       bcd_adj;
   int                msd;

   function automatic logic [6:0] seg_code(input logic [3:0] s);
      logic [6:0] c;
      case (s)
         4'd0:      c = 7'b1000000;
         4'd1:      c = 7'b1111001;
         4'd2:      c = 7'b0100100;
         4'd3:      c = 7'b0110000;
         4'd4:      c = 7'b0011001;
         4'd5:      c = 7'b0010010;
         4'd6:      c = 7'b0000010;
         4'd7:      c = 7'b1111000;
         4'd8:      c = 7'b0000000;
         4'd9:      c = 7'b0010000;
         SYM_MINUS: c = 7'b0111111;
         SYM_E:     c = 7'b0000110;
         SYM_R:     c = 7'b0101111;
         SYM_O:     c = 7'b0100011;
         default:   c = 7'b1111111;
      endcase
      return c;
   endfunction

   assign abs_w = work_q[31] ? (~work_q + 32'd1) : work_q;

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                                 : bcd_q[4*gi +: 4];
      end
   endgenerate

   // Display image for the converted value: leading zeros blanked, minus hugs the top digit
   always_comb begin
      msd = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = i;
      end
      for (int i = 0; i < DIGITS; i++) begin
         fmt[i] = SYM_BLANK;
         case (kind_q)
            K_ERR: begin
               case (i)
                  5:       fmt[i] = SYM_E;
                  4:       fmt[i] = SYM_R;
                  3:       fmt[i] = SYM_R;
                  2:       fmt[i] = SYM_O;
                  1:       fmt[i] = SYM_R;
                  default: fmt[i] = SYM_BLANK;
               endcase
            end
            K_NUM: begin
               if (i <= msd)                     fmt[i] = bcd_q[4*i +: 4];
               else if (neg_q && i == msd + 1)   fmt[i] = SYM_MINUS;
            end
            default: fmt[i] = SYM_BLANK;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      shadow_d = shadow_q;
      work_d   = work_q;
      mag_d    = mag_q;
      bcd_d    = bcd_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      digit_d  = digit_q;
      case (state_q)
         IDLE: begin
            if (ans != shadow_q) begin
               shadow_d = ans;
               work_d   = ans;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            if (work_q == ANS_NULL) begin
               kind_d  = K_NULL;
               state_d = FORMAT;
            end else if (work_q == ANS_ERR || $signed(work_q) >= 32'sd1000000 ||
                         $signed(work_q) <= -32'sd100000) begin
               kind_d  = K_ERR;
               state_d = FORMAT;
            end else begin
               kind_d  = K_NUM;
               neg_d   = work_q[31];
               mag_d   = abs_w[19:0];
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, mag_d} = {bcd_adj[22:0], mag_q, 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd19) state_d = FORMAT;
         end
         FORMAT: begin
            digit_d = fmt;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan outputs are built from the next-state index and digits so they move together
   always_comb begin
      scan_d = (scan_q == CW'(SCAN_DIV - 1)) ? '0 : scan_q + CW'(1);
      idx_d  = idx_q;
      if (scan_q == CW'(SCAN_DIV - 1)) begin
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
      seg_d = {1'b1, seg_code(digit_d[idx_d])};
      sel_d = ~(DIGITS'(1) << idx_d);
   end

   always_ff @(posedge sw_clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         kind_q   <= K_NULL;
         shadow_q <= ANS_NULL;
         work_q   <= '0;
         mag_q    <= '0;
         bcd_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         for (int i = 0; i < DIGITS; i++) digit_q[i] <= SYM_BLANK;
         scan_q   <= '0;
         idx_q    <= '0;
         seg_q    <= 8'hFF;
         sel_q    <= '1;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         shadow_q <= shadow_d;
         work_q   <= work_d;
         mag_q    <= mag_d;
         bcd_q    <= bcd_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         digit_q  <= digit_d;
         scan_q   <= scan_d;
         idx_q    <= idx_d;
         seg_q    <= seg_d;
         sel_q    <= sel_d;
      end
   end

   assign seg       = seg_q;
   assign digit_sel = sel_q;
   assign busy      = (state_q != IDLE);

endmodule
